stopwatch_mmss_counter: RTL and testbench
=========================================

// Module: stopwatch_mmss_counter
// PURPOSE
//  Registered MM:SS BCD time counter for the stopwatch, up or down.
//  Consumes the per-digit increment/decrement (carry/borrow) events the digit adder produces
//  and keeps the time state. A start/stop FSM controls it. Sits between the tick source and
//  the 7-segment display driver.
// PARAMETERS
//  MM_MAX   59  highest minute value (decimal, 1..99); MM_MAX:59 is full scale
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  tick       in   1   1-cycle count-enable pulse, 1 Hz nominal
//  start      in   1   pulse: begin/resume counting
//  stop       in   1   pulse: pause counting
//  clear      in   1   pulse: time := 00:00, FSM -> IDLE
//  dir        in   1   0 = count up, 1 = count down; sampled on start only
//  load       in   1   pulse: time := load_val (IDLE/PAUSE/DONE only)
//  load_val   in   16  BCD {min_t,min_u,sec_t,sec_u}
//  time_bcd   out  16  current BCD {min_t,min_u,sec_t,sec_u}
//  running    out  1   1 while FSM == RUN
//  rollover   out  1   1-cycle pulse: up-count wrapped MM_MAX:59 -> 00:00
//  done       out  1   1 while FSM == DONE (down-count reached 00:00)
//  lap_bcd    out  16  captured lap time (LAP_EN only, else constant 0)
//  lap        in   1   pulse: capture lap (LAP_EN only, else ignored)
// BEHAVIOUR
//  Reset: time_bcd = 0, lap_bcd = 0, running = 0, rollover = 0, done = 0, dir_q = 0, FSM = IDLE.
//  FSM states: IDLE, RUN, PAUSE, DONE.
//   IDLE -start-> RUN (dir_q := dir).
//   RUN -stop-> PAUSE.
//   PAUSE -start-> RUN (dir_q := dir).
//   RUN, down, tick at 00:01 -> 00:00 then DONE.
//   DONE -start-> stays DONE while time == 00:00. It goes to RUN once load sets a nonzero
//   value or dir = 0.
//   Any state -clear-> IDLE.
//  Priority each cycle: clear > load > start > stop > tick. start and stop in the same
//  cycle: start wins.
//  Counting applies only in RUN with tick = 1. Time changes in the cycle after the tick
//  (1-cycle latency). running updates in the same edge as the state.
//  Up: sec_u 9->0 carries into sec_t; sec_t 5->0 carries into minutes.
//   Minutes count 00..MM_MAX. MM_MAX:59 -> 00:00 with a rollover pulse; FSM stays RUN.
//  Down: sec_u 0->9 borrows from sec_t; sec_t 0->5 borrows from minutes.
//   Reaching 00:00 -> DONE. No further decrement happens; the counter never goes below 00:00.
//  load in RUN is ignored.
//  load_val digits >9 (sec_t >5) or minutes >MM_MAX are clamped to MM_MAX:59.
//  tick during IDLE/PAUSE/DONE: no effect.
//  dir change mid-RUN: ignored until the next start.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//   lap in RUN or PAUSE: lap_bcd := time_bcd on the next edge. Counting is not disturbed.
//   clear zeroes lap_bcd.
//  STOPWATCH_LAP_EN undefined: no lap register; lap is ignored; lap_bcd is tied to 16'h0000.
// STRUCTURE
//  stopwatch_pkg:
//   sw_state_e enum {IDLE, RUN, PAUSE, DONE}
//   bcd_t = logic [3:0]
//   SEC_T_MAX = 5, BCD_MAX = 9
//   mmss_t packed struct of four bcd_t
//  Sub-module bcd_digit_counter:
//   parameter MOD
//   inputs en, dir, ld, ld_val
//   outputs q, carry_out, borrow_out (combinational, flags the terminal value while en)
//   Four instances are chained by en = tick & all lower carries/borrows. Minute-limit logic
//   and the FSM live in the top.
// TESTING
//  1 reset mid-count at 12:34 -> all outputs 0 and FSM IDLE on the same edge; outputs hold
//    after rst_n rises.
//  2 up from 00:58: start, 2 ticks -> 00:59 then 01:00; 09:59 + tick -> 10:00.
//  3 load 59:59 (MM_MAX = 59), start up, tick -> 00:00 with a 1-cycle rollover pulse;
//    running stays 1.
//  4 load 01:00, dir = 1, start, tick -> 00:59. Load 00:02: 2 ticks -> 00:00, done = 1;
//    further ticks -> still 00:00.
//  5 RUN at 03:07, stop + tick in same cycle -> 03:07 and PAUSE. start + stop together
//    -> RUN. clear + load together -> 00:00 and IDLE.
//  6 (LAP_EN) RUN at 00:15, lap -> lap_bcd = 16'h0015; 3 ticks -> time 00:18,
//    lap_bcd unchanged. Non-LAP build -> lap_bcd = 0 always.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the MM:SS stopwatch counter.
//   sw_state_e : start/stop FSM states
//   bcd_t      : one BCD digit
//   mmss_t     : packed {min_t, min_u, sec_t, sec_u} time value (16 bits)
//   clamp_mmss : forces an out-of-range load value to full scale
package stopwatch_pkg;

   localparam int unsigned BCD_W     = 4;
   localparam int unsigned SEC_T_MAX = 5;
   localparam int unsigned BCD_MAX   = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } sw_state_e;

   typedef logic [BCD_W-1:0] bcd_t;

   typedef struct packed {
      bcd_t min_t;
      bcd_t min_u;
      bcd_t sec_t;
      bcd_t sec_u;
   } mmss_t;

   // Any illegal digit or a minute value above mm_max maps to mm_max:59.
   function automatic mmss_t clamp_mmss(input mmss_t v, input int unsigned mm_max);
      mmss_t       full;
      int unsigned mins;
      full.min_t = 4'(mm_max / 10);
      full.min_u = 4'(mm_max % 10);
      full.sec_t = 4'(SEC_T_MAX);
      full.sec_u = 4'(BCD_MAX);
      mins = 32'(10) * 32'(v.min_t) + 32'(v.min_u);
      if ((v.min_t > 4'(BCD_MAX)) || (v.min_u > 4'(BCD_MAX)) ||
          (v.sec_t > 4'(SEC_T_MAX)) || (v.sec_u > 4'(BCD_MAX)) || (mins > mm_max)) begin
         return full;
      end
      return v;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One modulo-MOD BCD digit, counting up or down when enabled.
//   clk, rst_n  : clock, async active-low reset
//   en          : step this digit this cycle
//   dir         : 0 = up, 1 = down
//   ld, ld_val  : synchronous load (wins over en)
//   q           : registered digit value
//   carry_out   : en & up   & q at MOD-1 (combinational)
//   borrow_out  : en & down & q at 0     (combinational)
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MOD = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic dir,
   input  logic ld,
   input  bcd_t ld_val,
   output bcd_t q,
   output logic carry_out,
   output logic borrow_out
);

   localparam bcd_t TOP = 4'(MOD - 1);

   assign carry_out  = en & ~dir & (q == TOP);
   assign borrow_out = en &  dir & (q == 4'd0);

   // Digit register with wrap in both directions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (ld) begin
         q <= ld_val;
      end else if (en) begin
         if (dir) begin
            q <= (q == 4'd0) ? TOP : q - 4'd1;
         end else begin
            q <= (q == TOP) ? 4'd0 : q + 4'd1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_mmss_counter.sv
// Registered MM:SS BCD stopwatch counter (up/down) with start/stop FSM.
// Optional lap capture register enabled by `define STOPWATCH_LAP_EN.
//   clk, rst_n : clock, async active-low reset
//   tick       : 1-cycle count enable
//   start/stop : begin/resume, pause
//   clear      : time and lap := 0, FSM -> IDLE
//   dir        : 0 up / 1 down, sampled on start
//   load       : time := clamped load_val (not in RUN)
//   time_bcd   : {min_t,min_u,sec_t,sec_u}
//   running    : FSM == RUN
//   rollover   : pulse when up-count wraps MM_MAX:59 -> 00:00
//   done       : FSM == DONE
//   lap, lap_bcd : lap capture request / captured time (0 without lap build)
module stopwatch_mmss_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned MM_MAX = 59
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        dir,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic [15:0] time_bcd,
   output logic        running,
   output logic        rollover,
   output logic        done,
   output logic [15:0] lap_bcd,
   input  logic        lap
);

   localparam bcd_t MM_T = 4'(MM_MAX / 10);
   localparam bcd_t MM_U = 4'(MM_MAX % 10);

   sw_state_e state;
   logic      dir_q;
   mmss_t     cur;
   mmss_t     clamped;
   mmss_t     ld_digits;

   logic load_ok, count_ok, cnt_en, wrap;
   logic is_zero, is_one, at_full;
   logic ld_all, min_ld;
   bcd_t min_t_val, min_u_val;

   logic su_c, su_b, st_c, st_b, mu_c, mu_b;
   logic mt_carry_unused, mt_borrow_unused;

   assign clamped   = clamp_mmss(mmss_t'(load_val), MM_MAX);
   assign is_zero   = (cur == mmss_t'(16'h0000));
   assign is_one    = (cur == mmss_t'(16'h0001));
   assign at_full   = (cur.min_t == MM_T) && (cur.min_u == MM_U) &&
                      (cur.sec_t == 4'(SEC_T_MAX)) && (cur.sec_u == 4'(BCD_MAX));

   // A tick counts only in RUN and only if no higher-priority control is active.
   assign load_ok   = load & ~clear & (state != RUN);
   assign count_ok  = tick & ~clear & ~start & ~stop & (state == RUN);
   // Down-count floors at 00:00.
   assign cnt_en    = count_ok & ~(dir_q & is_zero);
   // Full-scale up wrap: seconds wrap by themselves, minutes are forced to 00.
   assign wrap      = count_ok & ~dir_q & at_full;

   assign ld_all    = clear | load_ok;
   assign ld_digits = clear ? mmss_t'(16'h0000) : clamped;
   assign min_ld    = ld_all | wrap;
   assign min_t_val = ld_all ? ld_digits.min_t : 4'd0;
   assign min_u_val = ld_all ? ld_digits.min_u : 4'd0;

   bcd_digit_counter #(.MOD(BCD_MAX + 1)) u_sec_u (
      .clk(clk), .rst_n(rst_n), .en(cnt_en), .dir(dir_q),
      .ld(ld_all), .ld_val(ld_digits.sec_u), .q(cur.sec_u),
      .carry_out(su_c), .borrow_out(su_b)
   );

   bcd_digit_counter #(.MOD(SEC_T_MAX + 1)) u_sec_t (
      .clk(clk), .rst_n(rst_n), .en(su_c | su_b), .dir(dir_q),
      .ld(ld_all), .ld_val(ld_digits.sec_t), .q(cur.sec_t),
      .carry_out(st_c), .borrow_out(st_b)
   );

   bcd_digit_counter #(.MOD(BCD_MAX + 1)) u_min_u (
      .clk(clk), .rst_n(rst_n), .en(st_c | st_b), .dir(dir_q),
      .ld(min_ld), .ld_val(min_u_val), .q(cur.min_u),
      .carry_out(mu_c), .borrow_out(mu_b)
   );

   bcd_digit_counter #(.MOD(BCD_MAX + 1)) u_min_t (
      .clk(clk), .rst_n(rst_n), .en(mu_c | mu_b), .dir(dir_q),
      .ld(min_ld), .ld_val(min_t_val), .q(cur.min_t),
      .carry_out(mt_carry_unused), .borrow_out(mt_borrow_unused)
   );

   assign time_bcd = cur;

   // Start/stop FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         dir_q    <= 1'b0;
         running  <= 1'b0;
         done     <= 1'b0;
         rollover <= 1'b0;
      end else begin
         rollover <= wrap;
         if (clear) begin
            state   <= IDLE;
            running <= 1'b0;
            done    <= 1'b0;
         end else if (!load_ok) begin
            case (state)
               IDLE, PAUSE: begin
                  if (start) begin
                     state   <= RUN;
                     running <= 1'b1;
                     dir_q   <= dir;
                  end
               end
               RUN: begin
                  if (!start && stop) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (count_ok && dir_q && (is_zero || is_one)) begin
                     state   <= DONE;
                     running <= 1'b0;
                     done    <= 1'b1;
                  end
               end
               DONE: begin
                  // Leave only if there is something to count.
                  if (start && (!dir || !is_zero)) begin
                     state   <= RUN;
                     running <= 1'b1;
                     done    <= 1'b0;
                     dir_q   <= dir;
                  end
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
                  done    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [15:0] lap_q;

   // Lap snapshot of the current time; does not disturb counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lap_q <= 16'h0000;
      end else if (clear) begin
         lap_q <= 16'h0000;
      end else if (lap && ((state == RUN) || (state == PAUSE))) begin
         lap_q <= cur;
      end
   end

   assign lap_bcd = lap_q;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign lap_bcd    = 16'h0000;
`endif

endmodule

// File: tb/tb_stopwatch_mmss_counter.sv
// Scoreboard bench for stopwatch_mmss_counter (MM_MAX = 59).
// Stimulus pushes hand-computed expectations tagged with the cycle they
// apply to; a monitor pops and compares them on the falling edge.
module tb_stopwatch_mmss_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick, start, stop, clear, dir, load, lap;
   logic [15:0] load_val;
   logic [15:0] time_bcd, lap_bcd;
   logic        running, rollover, done;

   stopwatch_mmss_counter #(.MM_MAX(59)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
      .clear(clear), .dir(dir), .load(load), .load_val(load_val),
      .time_bcd(time_bcd), .running(running), .rollover(rollover),
      .done(done), .lap_bcd(lap_bcd), .lap(lap)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] NO = 7'h00, ST = 7'h40, SP = 7'h20, CL = 7'h10,
                          LD = 7'h08, TK = 7'h04, DR = 7'h02, LP = 7'h01;
   localparam logic [2:0] F0 = 3'b000, FR = 3'b100, FD = 3'b010, FO = 3'b001;

   typedef struct {
      string       name;
      logic [15:0] t;
      logic [2:0]  flags;
      logic [15:0] lp;
      int unsigned tag;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_m;
   int unsigned cyc = 0;
   int unsigned n_total = 0;
   int unsigned n_pass  = 0;
   logic [15:0] exp_lap = 16'h0000;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due on this cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].tag == cyc) begin
         e_m = sb.pop_front();
         n_total++;
         if (time_bcd === e_m.t && {running, done, rollover} === e_m.flags &&
             lap_bcd === e_m.lp) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got time=%h run/done/ro=%b lap=%h, expected time=%h run/done/ro=%b lap=%h",
                     e_m.name, time_bcd, {running, done, rollover}, lap_bcd,
                     e_m.t, e_m.flags, e_m.lp);
         end
      end
   end

   task automatic push_exp(input string nm, input logic [15:0] et, input logic [2:0] ef);
      exp_t e;
      e.name  = nm;
      e.t     = et;
      e.flags = ef;
      e.lp    = exp_lap;
      e.tag   = cyc + 1;
      sb.push_back(e);
   endtask

   // Apply one cycle of inputs and queue the state expected after the next edge.
   task automatic step(input string nm, input logic [6:0] ctl, input logic [15:0] lv,
                       input logic [15:0] et, input logic [2:0] ef);
      @(negedge clk);
      {start, stop, clear, load, tick, dir, lap} = ctl;
      load_val = lv;
      push_exp(nm, et, ef);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      {start, stop, clear, load, tick, dir, lap} = 7'h00;
      load_val = 16'h0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      step("reset_idle",   NO,      16'h0000, 16'h0000, F0);
      step("idle_tick",    TK,      16'h0000, 16'h0000, F0);

      // Up counting with seconds and minutes carries.
      step("load_0058",    LD,      16'h0058, 16'h0058, F0);
      step("start_up",     ST,      16'h0000, 16'h0058, FR);
      step("up_0059",      TK,      16'h0000, 16'h0059, FR);
      step("up_0100",      TK,      16'h0000, 16'h0100, FR);
      step("load_in_run",  LD,      16'h0500, 16'h0100, FR);
      step("stop",         SP,      16'h0000, 16'h0100, F0);
      step("load_0959",    LD,      16'h0959, 16'h0959, F0);
      step("resume",       ST,      16'h0000, 16'h0959, FR);
      step("up_1000",      TK,      16'h0000, 16'h1000, FR);
      step("dir_midrun",   TK | DR, 16'h0000, 16'h1001, FR);

      // Full-scale wrap.
      step("stop2",        SP,      16'h0000, 16'h1001, F0);
      step("load_5959",    LD,      16'h5959, 16'h5959, F0);
      step("start_5959",   ST,      16'h0000, 16'h5959, FR);
      step("wrap_0000",    TK,      16'h0000, 16'h0000, FR | FO);
      step("ro_pulse_end", NO,      16'h0000, 16'h0000, FR);
      step("after_wrap",   TK,      16'h0000, 16'h0001, FR);

      // Down counting, floor at 00:00 and DONE exits.
      step("stop3",        SP,      16'h0000, 16'h0001, F0);
      step("load_0100",    LD,      16'h0100, 16'h0100, F0);
      step("start_down",   ST | DR, 16'h0000, 16'h0100, FR);
      step("down_0059",    TK,      16'h0000, 16'h0059, FR);
      step("stop4",        SP,      16'h0000, 16'h0059, F0);
      step("load_0002",    LD,      16'h0002, 16'h0002, F0);
      step("start_down2",  ST | DR, 16'h0000, 16'h0002, FR);
      step("down_0001",    TK,      16'h0000, 16'h0001, FR);
      step("down_done",    TK,      16'h0000, 16'h0000, FD);
      step("done_floor",   TK,      16'h0000, 16'h0000, FD);
      step("done_start_dn",ST | DR, 16'h0000, 16'h0000, FD);
      step("done_load",    LD,      16'h0003, 16'h0003, FD);
      step("done_restart", ST | DR, 16'h0000, 16'h0003, FR);
      step("down_0002",    TK,      16'h0000, 16'h0002, FR);
      step("down_0001b",   TK,      16'h0000, 16'h0001, FR);
      step("down_done2",   TK,      16'h0000, 16'h0000, FD);
      step("done_start_up",ST,      16'h0000, 16'h0000, FR);
      step("up_from_done", TK,      16'h0000, 16'h0001, FR);

      // Control priorities.
      step("clear",        CL,      16'h0000, 16'h0000, F0);
      step("load_0306",    LD,      16'h0306, 16'h0306, F0);
      step("load_start",   LD | ST, 16'h0400, 16'h0400, F0);
      step("load_0306b",   LD,      16'h0306, 16'h0306, F0);
      step("start_0306",   ST,      16'h0000, 16'h0306, FR);
      step("up_0307",      TK,      16'h0000, 16'h0307, FR);
      step("stop_tick",    SP | TK, 16'h0000, 16'h0307, F0);
      step("start_stop",   ST | SP, 16'h0000, 16'h0307, FR);
      step("up_0308",      TK,      16'h0000, 16'h0308, FR);
      step("clear_load",   CL | LD, 16'h1234, 16'h0000, F0);

      // Load clamping.
      step("clamp_digit",  LD,      16'h0A00, 16'h5959, F0);
      step("clamp_min",    LD,      16'h6000, 16'h5959, F0);
      step("clamp_sec_t",  LD,      16'h0070, 16'h5959, F0);
      step("load_legal",   LD,      16'h4509, 16'h4509, F0);

      // Lap capture (constant 0 without the lap build).
      step("clear2",       CL,      16'h0000, 16'h0000, F0);
      step("load_0015",    LD,      16'h0015, 16'h0015, F0);
      step("start_0015",   ST,      16'h0000, 16'h0015, FR);
`ifdef STOPWATCH_LAP_EN
      exp_lap = 16'h0015;
`endif
      step("lap_0015",     LP,      16'h0000, 16'h0015, FR);
      step("lap_t16",      TK,      16'h0000, 16'h0016, FR);
      step("lap_t17",      TK,      16'h0000, 16'h0017, FR);
      step("lap_t18",      TK,      16'h0000, 16'h0018, FR);
`ifdef STOPWATCH_LAP_EN
      exp_lap = 16'h0018;
`endif
      step("lap_with_tick",LP | TK, 16'h0000, 16'h0019, FR);
      step("lap_stop",     SP,      16'h0000, 16'h0019, F0);
`ifdef STOPWATCH_LAP_EN
      exp_lap = 16'h0019;
`endif
      step("lap_pause",    LP,      16'h0000, 16'h0019, F0);
      exp_lap = 16'h0000;
      step("clear_lap",    CL,      16'h0000, 16'h0000, F0);
      step("lap_idle",     LP,      16'h0000, 16'h0000, F0);

      // Asynchronous reset while counting at 12:34.
      step("load_1233",    LD,      16'h1233, 16'h1233, F0);
      step("start_1233",   ST,      16'h0000, 16'h1233, FR);
      step("up_1234",      TK,      16'h0000, 16'h1234, FR);
      @(negedge clk);
      {start, stop, clear, load, tick, dir, lap} = TK;
      rst_n = 1'b0;
      push_exp("reset_mid", 16'h0000, F0);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp("reset_hold", 16'h0000, F0);
      step("post_reset",   TK,      16'h0000, 16'h0000, F0);
      step("post_start",   ST,      16'h0000, 16'h0000, FR);
      step("post_tick",    TK,      16'h0000, 16'h0001, FR);

      step("idle_end",     NO,      16'h0000, 16'h0001, FR);
      repeat (2) @(negedge clk);
      if (sb.size() != 0) begin
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
         n_total += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
